// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, FSM state codes,
// ALU-op codes and the ALU source-B / PC source mux selects.
package mips_mc_pkg;

  localparam int unsigned OPC_W   = 6;
  localparam int unsigned STATE_W = 4;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OP_J     = 6'h02;
  localparam logic [OPC_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPC_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OPC_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPC_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_FAULT  = 4'd12,
    S_JAL    = 4'd13
  } state_t;

  // ALU-op codes; IMM2 is the shared immediate-logic code of the narrow encoding
  localparam logic [2:0] ALUOP_ADD   = 3'd0;
  localparam logic [2:0] ALUOP_SUB   = 3'd1;
  localparam logic [2:0] ALUOP_FUNCT = 3'd2;
  localparam logic [2:0] ALUOP_SLT   = 3'd3;
  localparam logic [2:0] ALUOP_AND   = 3'd4;
  localparam logic [2:0] ALUOP_OR    = 3'd5;
  localparam logic [2:0] ALUOP_XOR   = 3'd6;
  localparam logic [2:0] ALUOP_IMM2  = 3'd3;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-handshake wait counter: counts held cycles and flags the last allowed one.
// WAIT_MAX = 0 disables the limit entirely.
module mc_wait_timer #(
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_hold,
  output logic o_expire_c
);

  if (WAIT_MAX > 0) begin : g_timer
    localparam int unsigned CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    logic [CNT_W-1:0] r_cnt;

    // Any cycle that is not a plain hold restarts the count for the next wait state
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_cnt <= '0;
      end else if (i_hold) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
    end

    assign o_expire_c = (r_cnt == CNT_W'(WAIT_MAX - 1));
  end else begin : g_no_timer
    assign o_expire_c = 1'b0;
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main control FSM with memory wait timeout.
// Optional MIPS_MC_JAL_EN adds the JAL link-and-jump state.
module mips_mc_control
  import mips_mc_pkg::*;
#(
  parameter int unsigned ALUOP_W  = 2,
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [OPC_W-1:0]   i_opcode,
  input  logic               i_memReady,
  output logic               o_memReq,
  output logic               o_memRead,
  output logic               o_memWrite,
  output logic               o_iorD,
  output logic               o_irWrite,
  output logic               o_pcWrite,
  output logic               o_branch,
  output logic               o_bne,
  output logic               o_regDst,
  output logic               o_memToReg,
  output logic               o_regWrite,
  output logic               o_aluSrcA,
  output logic               o_extOp,
  output logic               o_link,
  output logic               o_fault,
  output logic [1:0]         o_aluSrcB,
  output logic [1:0]         o_pcSrc,
  output logic [ALUOP_W-1:0] o_aluOp,
  output logic [STATE_W-1:0] o_state
);

  state_t     r_state;
  state_t     w_next;
  logic       w_expire;
  logic       w_hold;
  logic [2:0] w_imm_op;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  assign w_hold = ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR))
                  && !i_memReady && !w_expire;

  mc_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_hold     (w_hold),
    .o_expire_c (w_expire)
  );

  // Full-width immediate op; the narrow encoding folds every logic op onto IMM2
  always_comb begin
    w_imm_op = ALUOP_ADD;
    case (i_opcode)
      OP_SLTI: w_imm_op = ALUOP_SLT;
      OP_ANDI: w_imm_op = ALUOP_AND;
      OP_ORI:  w_imm_op = ALUOP_OR;
      OP_XORI: w_imm_op = ALUOP_XOR;
      default: w_imm_op = ALUOP_ADD;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    o_memReq   = 1'b0;
    o_memRead  = 1'b0;
    o_memWrite = 1'b0;
    o_iorD     = 1'b0;
    o_irWrite  = 1'b0;
    o_pcWrite  = 1'b0;
    o_branch   = 1'b0;
    o_bne      = 1'b0;
    o_regDst   = 1'b0;
    o_memToReg = 1'b0;
    o_regWrite = 1'b0;
    o_aluSrcA  = 1'b0;
    o_extOp    = 1'b0;
`ifdef MIPS_MC_JAL_EN
    o_link     = 1'b0;
`endif
    o_fault    = 1'b0;
    o_aluSrcB  = SRCB_REG;
    o_pcSrc    = PCSRC_ALU;
    o_aluOp    = ALUOP_W'(ALUOP_ADD);
    o_state    = r_state;

    // Reset silences every control line so an in-flight access is dropped at once
    if (!i_rst) begin
      case (r_state)
        S_FETCH: begin
          o_memReq  = 1'b1;
          o_memRead = 1'b1;
          o_aluSrcB = SRCB_FOUR;
          o_irWrite = i_memReady;
          o_pcWrite = i_memReady;
          if (i_memReady)    w_next = S_DECODE;
          else if (w_expire) w_next = S_FAULT;
        end
        S_DECODE: begin
          o_aluSrcB = SRCB_BRANCH;
          case (i_opcode)
            OP_LW, OP_SW:     w_next = S_MEMADR;
            OP_RTYPE:         w_next = S_EXEC;
            OP_BEQ, OP_BNE:   w_next = S_BRANCH;
            OP_ADDI, OP_ADDIU, OP_SLTI,
            OP_ANDI, OP_ORI, OP_XORI: w_next = S_IEXEC;
            OP_J:             w_next = S_JUMP;
`ifdef MIPS_MC_JAL_EN
            OP_JAL:           w_next = S_JAL;
`endif
            default:          w_next = S_FETCH;
          endcase
        end
        S_MEMADR: begin
          o_aluSrcA = 1'b1;
          o_aluSrcB = SRCB_IMM;
          w_next    = (i_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          o_memReq  = 1'b1;
          o_memRead = 1'b1;
          o_iorD    = 1'b1;
          if (i_memReady)    w_next = S_MEMWB;
          else if (w_expire) w_next = S_FAULT;
        end
        S_MEMWB: begin
          o_memToReg = 1'b1;
          o_regWrite = 1'b1;
          w_next     = S_FETCH;
        end
        S_MEMWR: begin
          o_memReq   = 1'b1;
          o_memWrite = 1'b1;
          o_iorD     = 1'b1;
          if (i_memReady)    w_next = S_FETCH;
          else if (w_expire) w_next = S_FAULT;
        end
        S_EXEC: begin
          o_aluSrcA = 1'b1;
          o_aluOp   = ALUOP_W'(ALUOP_FUNCT);
          w_next    = S_ALUWB;
        end
        S_ALUWB: begin
          o_regDst   = 1'b1;
          o_regWrite = 1'b1;
          w_next     = S_FETCH;
        end
        S_BRANCH: begin
          o_aluSrcA = 1'b1;
          o_aluOp   = ALUOP_W'(ALUOP_SUB);
          o_pcSrc   = PCSRC_BRANCH;
          o_branch  = (i_opcode == OP_BEQ);
          o_bne     = (i_opcode == OP_BNE);
          w_next    = S_FETCH;
        end
        S_IEXEC: begin
          o_aluSrcA = 1'b1;
          o_aluSrcB = SRCB_IMM;
          o_extOp   = (i_opcode == OP_ANDI) || (i_opcode == OP_ORI) || (i_opcode == OP_XORI);
          if (ALUOP_W == 3)                o_aluOp = ALUOP_W'(w_imm_op);
          else if (w_imm_op == ALUOP_ADD)  o_aluOp = ALUOP_W'(ALUOP_ADD);
          else                             o_aluOp = ALUOP_W'(ALUOP_IMM2);
          w_next = S_IWB;
        end
        S_IWB: begin
          o_regWrite = 1'b1;
          w_next     = S_FETCH;
        end
        S_JUMP: begin
          o_pcSrc   = PCSRC_JUMP;
          o_pcWrite = 1'b1;
          w_next    = S_FETCH;
        end
        S_FAULT: begin
          o_fault = 1'b1;
          w_next  = S_FAULT;
        end
`ifdef MIPS_MC_JAL_EN
        S_JAL: begin
          o_pcSrc    = PCSRC_JUMP;
          o_pcWrite  = 1'b1;
          o_regWrite = 1'b1;
          o_link     = 1'b1;
          w_next     = S_FETCH;
        end
`endif
        default: w_next = S_FETCH;
      endcase
    end
  end

`ifndef MIPS_MC_JAL_EN
  assign o_link = 1'b0;
`endif

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: two instances (ALUOP_W=2/WAIT_MAX=16 and ALUOP_W=3/WAIT_MAX=4)
// share stimulus and are checked every cycle against an instruction-path model.
module tb_mips_mc_control;

  logic       clk = 1'b0;
  logic       rst;
  logic       rdy;
  logic [5:0] op;
  logic       run = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic fault, link, extop, srca, regwrite, memtoreg, regdst, bne, branch;
    logic pcwrite, irwrite, iord, memwrite, memread, memreq;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
    logic [3:0] state;
  } ctl_t;

  logic memReq[2], memRead[2], memWrite[2], iorD[2], irWrite[2], pcWrite[2];
  logic branch[2], bne[2], regDst[2], memToReg[2], regWrite[2], aluSrcA[2];
  logic extOp[2], link[2], fault[2];
  logic [1:0] aluSrcB[2];
  logic [1:0] pcSrc[2];
  logic [3:0] st[2];
  logic [1:0] aluop_a;
  logic [2:0] aluop_b;

  mips_mc_control #(.ALUOP_W(2), .WAIT_MAX(16)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_opcode(op), .i_memReady(rdy),
    .o_memReq(memReq[0]), .o_memRead(memRead[0]), .o_memWrite(memWrite[0]), .o_iorD(iorD[0]),
    .o_irWrite(irWrite[0]), .o_pcWrite(pcWrite[0]), .o_branch(branch[0]), .o_bne(bne[0]),
    .o_regDst(regDst[0]), .o_memToReg(memToReg[0]), .o_regWrite(regWrite[0]),
    .o_aluSrcA(aluSrcA[0]), .o_extOp(extOp[0]), .o_link(link[0]), .o_fault(fault[0]),
    .o_aluSrcB(aluSrcB[0]), .o_pcSrc(pcSrc[0]), .o_aluOp(aluop_a), .o_state(st[0])
  );

  mips_mc_control #(.ALUOP_W(3), .WAIT_MAX(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_opcode(op), .i_memReady(rdy),
    .o_memReq(memReq[1]), .o_memRead(memRead[1]), .o_memWrite(memWrite[1]), .o_iorD(iorD[1]),
    .o_irWrite(irWrite[1]), .o_pcWrite(pcWrite[1]), .o_branch(branch[1]), .o_bne(bne[1]),
    .o_regDst(regDst[1]), .o_memToReg(memToReg[1]), .o_regWrite(regWrite[1]),
    .o_aluSrcA(aluSrcA[1]), .o_extOp(extOp[1]), .o_link(link[1]), .o_fault(fault[1]),
    .o_aluSrcB(aluSrcB[1]), .o_pcSrc(pcSrc[1]), .o_aluOp(aluop_b), .o_state(st[1])
  );

  function automatic ctl_t act_of(int k);
    ctl_t c;
    c.fault = fault[k];       c.link = link[k];         c.extop = extOp[k];
    c.srca = aluSrcA[k];      c.regwrite = regWrite[k]; c.memtoreg = memToReg[k];
    c.regdst = regDst[k];     c.bne = bne[k];           c.branch = branch[k];
    c.pcwrite = pcWrite[k];   c.irwrite = irWrite[k];   c.iord = iorD[k];
    c.memwrite = memWrite[k]; c.memread = memRead[k];   c.memreq = memReq[k];
    c.srcb = aluSrcB[k];      c.pcsrc = pcSrc[k];
    c.aluop = (k == 0) ? {1'b0, aluop_a} : aluop_b;
    c.state = st[k];
    return c;
  endfunction

  // Model: each opcode walks a fixed state path; wait states stall on !ready
  int m_st[2];
  int m_wait[2];

  function automatic int wmax(int k);
    return (k == 0) ? 16 : 4;
  endfunction

  function automatic int next_of(int s, logic [5:0] o);
    int p[$];
    case (o)
      6'h23:                      p = {0, 1, 2, 3, 4};
      6'h2B:                      p = {0, 1, 2, 5};
      6'h00:                      p = {0, 1, 6, 7};
      6'h04, 6'h05:               p = {0, 1, 8};
      6'h08, 6'h09, 6'h0A,
      6'h0C, 6'h0D, 6'h0E:        p = {0, 1, 9, 10};
      6'h02:                      p = {0, 1, 11};
`ifdef MIPS_MC_JAL_EN
      6'h03:                      p = {0, 1, 13};
`endif
      default:                    p = {0, 1};
    endcase
    for (int i = 0; i < p.size() - 1; i++)
      if (p[i] == s) return p[i+1];
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_st[k] <= 0;
        m_wait[k] <= 0;
      end else if (m_st[k] == 12) begin
        m_st[k] <= 12;
      end else if ((m_st[k] == 0 || m_st[k] == 3 || m_st[k] == 5) && !rdy) begin
        if (wmax(k) > 0 && m_wait[k] + 1 >= wmax(k)) begin
          m_st[k] <= 12;
          m_wait[k] <= 0;
        end else begin
          m_wait[k] <= m_wait[k] + 1;
        end
      end else begin
        m_st[k] <= next_of(m_st[k], op);
        m_wait[k] <= 0;
      end
    end
  end

  function automatic ctl_t exp_of(int k);
    ctl_t c;
    c = '0;
    if (rst) return c;
    c.state = 4'(m_st[k]);
    case (m_st[k])
      0:  begin c.memreq = 1; c.memread = 1; c.srcb = 2'b01; c.irwrite = rdy; c.pcwrite = rdy; end
      1:  c.srcb = 2'b11;
      2:  begin c.srca = 1; c.srcb = 2'b10; end
      3:  begin c.memreq = 1; c.memread = 1; c.iord = 1; end
      4:  begin c.memtoreg = 1; c.regwrite = 1; end
      5:  begin c.memreq = 1; c.memwrite = 1; c.iord = 1; end
      6:  begin c.srca = 1; c.aluop = 3'd2; end
      7:  begin c.regdst = 1; c.regwrite = 1; end
      8:  begin c.srca = 1; c.aluop = 3'd1; c.pcsrc = 2'b01;
                c.branch = (op == 6'h04); c.bne = (op == 6'h05); end
      9:  begin
            c.srca = 1; c.srcb = 2'b10;
            c.extop = (op == 6'h0C) || (op == 6'h0D) || (op == 6'h0E);
            if (k == 1) begin
              case (op)
                6'h0A: c.aluop = 3'd3;
                6'h0C: c.aluop = 3'd4;
                6'h0D: c.aluop = 3'd5;
                6'h0E: c.aluop = 3'd6;
                default: c.aluop = 3'd0;
              endcase
            end else begin
              c.aluop = (op == 6'h08 || op == 6'h09) ? 3'd0 : 3'd3;
            end
          end
      10: c.regwrite = 1;
      11: begin c.pcsrc = 2'b10; c.pcwrite = 1; end
      12: c.fault = 1;
      13: begin c.pcsrc = 2'b10; c.pcwrite = 1; c.regwrite = 1; c.link = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      for (int k = 0; k < 2; k++)
        chk($sformatf("cycle_dut%0d", k), 32'(act_of(k)), 32'(exp_of(k)));
    end
  end

  ctl_t tra[$];
  ctl_t trb[$];

  task automatic cyc(input logic [5:0] o, input logic r);
    op = o;
    rdy = r;
    @(negedge clk);
    tra.push_back(act_of(0));
    trb.push_back(act_of(1));
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH back to FETCH, stalling fw fetch and mw memory cycles
  task automatic instr(input logic [5:0] o, input int fw, input int mw);
    int  fcnt, mcnt, n;
    logic r;
    fcnt = 0; mcnt = 0; n = 0;
    tra.delete(); trb.delete();
    while (n < 40) begin
      r = 1'b1;
      if (m_st[0] == 0 && fcnt < fw) begin r = 1'b0; fcnt++; end
      if ((m_st[0] == 3 || m_st[0] == 5) && mcnt < mw) begin r = 1'b0; mcnt++; end
      cyc(o, r);
      n++;
      if (m_st[0] == 0 && tra[$].state != 4'd0) break;
    end
    if (n >= 40) chk("instr_bound", 32'(n), 32'(0));
  endtask

  // Expected states as hex digits, first visited state leftmost
  task automatic check_seq(input string nm, input ctl_t t[$], input int n, input logic [63:0] s);
    chk({nm, "_len"}, 32'(t.size()), 32'(n));
    for (int i = 0; i < n && i < t.size(); i++)
      chk($sformatf("%s_st%0d", nm, i), 32'(t[i].state), 32'(s[4*(n-1-i) +: 4]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  ctl_t c;

  initial begin
    rst = 1'b1; op = 6'h00; rdy = 1'b1;
    repeat (2) @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    c = act_of(0);
    chk("rst_state", 32'(c.state), 32'd0);
    chk("rst_memreq", 32'(c.memreq), 32'd0);
    chk("rst_irwrite", 32'(c.irwrite), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    instr(6'h00, 0, 0);
    check_seq("rtype", tra, 4, 64'h0167);
    chk("rtype_fetch_req", 32'(tra[0].memreq), 32'd1);
    chk("rtype_funct", 32'(tra[2].aluop), 32'd2);
    chk("rtype_regdst", 32'(tra[3].regdst), 32'd1);
    chk("rtype_regwrite", 32'(tra[3].regwrite), 32'd1);

    instr(6'h23, 1, 3);
    check_seq("lw_a", tra, 9, 64'h001233334);
    check_seq("lw_b", trb, 9, 64'h001233334);
    chk("lw_irwrite_stall", 32'(tra[0].irwrite), 32'd0);
    chk("lw_irwrite_go", 32'(tra[1].irwrite), 32'd1);
    chk("lw_memtoreg", 32'(tra[8].memtoreg), 32'd1);
    chk("lw_nofault_b", 32'(trb[7].fault), 32'd0);

    instr(6'h05, 0, 0);
    check_seq("bne", tra, 3, 64'h018);
    chk("bne_bne", 32'(tra[2].bne), 32'd1);
    chk("bne_branch", 32'(tra[2].branch), 32'd0);
    chk("bne_pcsrc", 32'(tra[2].pcsrc), 32'd1);
    instr(6'h04, 0, 0);
    chk("beq_branch", 32'(tra[2].branch), 32'd1);
    chk("beq_bne", 32'(tra[2].bne), 32'd0);

    instr(6'h0D, 0, 0);
    check_seq("ori", tra, 4, 64'h019A);
    chk("ori_aluop_w2", 32'(tra[2].aluop), 32'd3);
    chk("ori_aluop_w3", 32'(trb[2].aluop), 32'd5);
    chk("ori_extop", 32'(trb[2].extop), 32'd1);
    instr(6'h08, 0, 0);
    chk("addi_aluop", 32'(trb[2].aluop), 32'd0);
    chk("addi_extop", 32'(tra[2].extop), 32'd0);
    instr(6'h0E, 0, 0);
    chk("xori_aluop_w3", 32'(trb[2].aluop), 32'd6);
    instr(6'h0C, 0, 0);
    chk("andi_aluop_w3", 32'(trb[2].aluop), 32'd4);
    instr(6'h0A, 0, 0);
    chk("slti_aluop_w2", 32'(tra[2].aluop), 32'd3);
    chk("slti_extop", 32'(tra[2].extop), 32'd0);

    instr(6'h02, 0, 0);
    check_seq("j", tra, 3, 64'h01B);
    chk("j_pcwrite", 32'(tra[2].pcwrite), 32'd1);
    chk("j_pcsrc", 32'(tra[2].pcsrc), 32'd2);

    instr(6'h03, 0, 0);
`ifdef MIPS_MC_JAL_EN
    check_seq("jal", tra, 3, 64'h01D);
    chk("jal_link", 32'(tra[2].link), 32'd1);
    chk("jal_regwrite", 32'(tra[2].regwrite), 32'd1);
    chk("jal_pcwrite", 32'(tra[2].pcwrite), 32'd1);
`else
    check_seq("jal_nop", tra, 2, 64'h01);
    chk("jal_nolink", 32'(tra[1].link), 32'd0);
`endif

    instr(6'h3F, 0, 0);
    check_seq("nop", tra, 2, 64'h01);

    // SW with memory never ready: the short-limit instance faults, the other keeps waiting
    tra.delete(); trb.delete();
    repeat (3) cyc(6'h2B, 1'b1);
    repeat (6) cyc(6'h2B, 1'b0);
    cyc(6'h2B, 1'b1);
    check_seq("sw_a", tra, 10, 64'h0125555555);
    check_seq("sw_b", trb, 10, 64'h0125555CCC);
    chk("sw_fault", 32'(trb[7].fault), 32'd1);
    chk("sw_fault_sticky", 32'(trb[9].fault), 32'd1);
    chk("sw_fault_memreq", 32'(trb[8].memreq), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    c = act_of(1);
    chk("fault_rst_state", 32'(c.state), 32'd0);
    chk("fault_rst_fault", 32'(c.fault), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    c = act_of(1);
    chk("fault_rel_memreq", 32'(c.memreq), 32'd1);
    chk("fault_rel_state", 32'(c.state), 32'd0);

    // Reset mid-read drops the request immediately
    tra.delete(); trb.delete();
    repeat (3) cyc(6'h23, 1'b1);
    cyc(6'h23, 1'b0);
    chk("abort_pre_memreq", 32'(tra[3].memreq), 32'd1);
    chk("abort_pre_iord", 32'(tra[3].iord), 32'd1);
    rst = 1'b1;
    #2;
    c = act_of(0);
    chk("abort_memreq", 32'(c.memreq), 32'd0);
    chk("abort_state", 32'(c.state), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    instr(6'h00, 0, 0);
    check_seq("post_abort", tra, 4, 64'h0167);

    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
